// File: rtl/json_pkg.sv
// Shared types for the JSON byte lexer: token kinds, lexer states,
// literal selection and ASCII constants, plus small classification helpers.
package json_pkg;

    typedef enum logic [4:0] {
        TOK_NONE      = 5'd0,
        TOK_LBRACE    = 5'd1,
        TOK_RBRACE    = 5'd2,
        TOK_LBRACK    = 5'd3,
        TOK_RBRACK    = 5'd4,
        TOK_COLON     = 5'd5,
        TOK_COMMA     = 5'd6,
        TOK_STR_START = 5'd7,
        TOK_STR_CHAR  = 5'd8,
        TOK_STR_ESC   = 5'd9,
        TOK_STR_END   = 5'd10,
        TOK_NUM_CHAR  = 5'd11,
        TOK_NUM_END   = 5'd12,
        TOK_LIT_TRUE  = 5'd13,
        TOK_LIT_FALSE = 5'd14,
        TOK_LIT_NULL  = 5'd15,
        TOK_ERROR     = 5'd16
    } json_tok_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STRING  = 3'd1,
        ST_ESCAPE  = 3'd2,
        ST_NUMBER  = 3'd3,
        ST_LITERAL = 3'd4,
        ST_ERROR   = 3'd5
    } lex_state_e;

    typedef enum logic [1:0] {
        LSEL_TRUE  = 2'd0,
        LSEL_FALSE = 2'd1,
        LSEL_NULL  = 2'd2
    } lit_sel_e;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_TAB    = 8'h09;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_RBRACK = 8'h5D;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_BSLASH = 8'h5C;
    localparam logic [7:0] CH_SLASH  = 8'h2F;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_LC_E   = 8'h65;
    localparam logic [7:0] CH_UC_E   = 8'h45;
    localparam logic [7:0] CH_T      = 8'h74;
    localparam logic [7:0] CH_F      = 8'h66;
    localparam logic [7:0] CH_N      = 8'h6E;
    localparam logic [7:0] CH_B      = 8'h62;
    localparam logic [7:0] CH_R      = 8'h72;
    localparam logic [7:0] CH_U      = 8'h75;
    localparam logic [7:0] CH_CTRL_LIMIT = 8'h20;

    function automatic logic is_ws(input logic [7:0] b);
        return (b == CH_SPACE) || (b == CH_TAB) || (b == CH_LF) || (b == CH_CR);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

    function automatic logic is_num_char(input logic [7:0] b);
        return is_digit(b) || (b == CH_DOT) || (b == CH_LC_E) || (b == CH_UC_E) ||
               (b == CH_PLUS) || (b == CH_MINUS);
    endfunction

    function automatic logic is_esc_char(input logic [7:0] b);
        return (b == CH_QUOTE) || (b == CH_BSLASH) || (b == CH_SLASH) || (b == CH_B) ||
               (b == CH_F) || (b == CH_N) || (b == CH_R) || (b == CH_T) || (b == CH_U);
    endfunction

    // Expected character at position idx of the selected literal keyword.
    function automatic logic [7:0] lit_char(input lit_sel_e sel, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case (sel)
            LSEL_TRUE: case (idx)
                3'd0: c = "t";  3'd1: c = "r";  3'd2: c = "u";  3'd3: c = "e";
                default: c = 8'h00;
            endcase
            LSEL_FALSE: case (idx)
                3'd0: c = "f";  3'd1: c = "a";  3'd2: c = "l";  3'd3: c = "s";  3'd4: c = "e";
                default: c = 8'h00;
            endcase
            LSEL_NULL: case (idx)
                3'd0: c = "n";  3'd1: c = "u";  3'd2: c = "l";  3'd3: c = "l";
                default: c = 8'h00;
            endcase
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Index of the final character of the selected literal keyword.
    function automatic logic [2:0] lit_last(input lit_sel_e sel);
        return (sel == LSEL_FALSE) ? 3'd4 : 3'd3;
    endfunction

    function automatic json_tok_e lit_tok(input lit_sel_e sel);
        json_tok_e k;
        case (sel)
            LSEL_TRUE:  k = TOK_LIT_TRUE;
            LSEL_FALSE: k = TOK_LIT_FALSE;
            default:    k = TOK_LIT_NULL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/json_lexer.sv
// Streaming JSON lexer: one byte in, at most one token out per cycle,
// through a single registered output slot. Number termination bytes are
// replayed as IDLE input so no byte is lost.
module json_lexer
    import json_pkg::*;
#(
    parameter int STRICT_CTRL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tok_valid,
    input  logic       tok_ready,
    output json_tok_e  tok_kind,
    output logic [7:0] tok_data,
    output logic       err
);

    lex_state_e state_q,  state_d;
    lit_sel_e   lit_sel_q, lit_sel_d;
    logic [2:0] lit_idx_q, lit_idx_d;
    logic       pend_q,   pend_d;
    logic [7:0] replay_q, replay_d;
    logic       err_q,    err_d;
    logic       tok_valid_q, tok_valid_d;
    json_tok_e  tok_kind_q,  tok_kind_d;
    logic [7:0] tok_data_q,  tok_data_d;

    logic       slot_free;
    logic       consume;
    logic [7:0] cur_byte;
    logic       emit;
    json_tok_e  emit_kind;
    logic [7:0] emit_data;
    logic       raise_err;

    // Output slot can take a new token when empty or being drained now.
    assign slot_free = !tok_valid_q || tok_ready;
    // A replayed byte has priority over fresh input (in_ready is low then).
    assign consume   = pend_q ? slot_free : (in_valid && in_ready);
    assign cur_byte  = pend_q ? replay_q : in_data;

    // State register: all lexer and output-slot flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lit_sel_q   <= LSEL_TRUE;
            lit_idx_q   <= 3'd0;
            pend_q      <= 1'b0;
            replay_q    <= 8'h00;
            err_q       <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_kind_q  <= TOK_NONE;
            tok_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            lit_sel_q   <= lit_sel_d;
            lit_idx_q   <= lit_idx_d;
            pend_q      <= pend_d;
            replay_q    <= replay_d;
            err_q       <= err_d;
            tok_valid_q <= tok_valid_d;
            tok_kind_q  <= tok_kind_d;
            tok_data_q  <= tok_data_d;
        end
    end

    // Next-state: classify the consumed byte, pick the token and transition.
    always_comb begin
        state_d     = state_q;
        lit_sel_d   = lit_sel_q;
        lit_idx_d   = lit_idx_q;
        pend_d      = pend_q;
        replay_d    = replay_q;
        err_d       = err_q;
        tok_valid_d = tok_valid_q;
        tok_kind_d  = tok_kind_q;
        tok_data_d  = tok_data_q;
        emit        = 1'b0;
        emit_kind   = TOK_NONE;
        emit_data   = 8'h00;
        raise_err   = 1'b0;

        // Slot drains unless refilled below; a stalled slot holds its value.
        if (slot_free) begin
            tok_valid_d = 1'b0;
            tok_kind_d  = TOK_NONE;
            tok_data_d  = 8'h00;
        end

        if (consume) begin
            pend_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (is_ws(cur_byte)) begin
                        emit = 1'b0;
                    end else if (cur_byte == CH_LBRACE) begin
                        emit = 1'b1; emit_kind = TOK_LBRACE;
                    end else if (cur_byte == CH_RBRACE) begin
                        emit = 1'b1; emit_kind = TOK_RBRACE;
                    end else if (cur_byte == CH_LBRACK) begin
                        emit = 1'b1; emit_kind = TOK_LBRACK;
                    end else if (cur_byte == CH_RBRACK) begin
                        emit = 1'b1; emit_kind = TOK_RBRACK;
                    end else if (cur_byte == CH_COLON) begin
                        emit = 1'b1; emit_kind = TOK_COLON;
                    end else if (cur_byte == CH_COMMA) begin
                        emit = 1'b1; emit_kind = TOK_COMMA;
                    end else if (cur_byte == CH_QUOTE) begin
                        emit = 1'b1; emit_kind = TOK_STR_START;
                        state_d = ST_STRING;
                    end else if ((cur_byte == CH_MINUS) || is_digit(cur_byte)) begin
                        emit = 1'b1; emit_kind = TOK_NUM_CHAR; emit_data = cur_byte;
                        state_d = ST_NUMBER;
                    end else if (cur_byte == CH_T) begin
                        lit_sel_d = LSEL_TRUE;  lit_idx_d = 3'd1; state_d = ST_LITERAL;
                    end else if (cur_byte == CH_F) begin
                        lit_sel_d = LSEL_FALSE; lit_idx_d = 3'd1; state_d = ST_LITERAL;
                    end else if (cur_byte == CH_N) begin
                        lit_sel_d = LSEL_NULL;  lit_idx_d = 3'd1; state_d = ST_LITERAL;
                    end else begin
                        raise_err = 1'b1;
                    end
                end
                ST_STRING: begin
                    if (cur_byte == CH_QUOTE) begin
                        emit = 1'b1; emit_kind = TOK_STR_END;
                        state_d = ST_IDLE;
                    end else if (cur_byte == CH_BSLASH) begin
                        state_d = ST_ESCAPE;
                    end else if ((STRICT_CTRL != 0) && (cur_byte < CH_CTRL_LIMIT)) begin
                        raise_err = 1'b1;
                    end else begin
                        emit = 1'b1; emit_kind = TOK_STR_CHAR; emit_data = cur_byte;
                    end
                end
                ST_ESCAPE: begin
                    if (is_esc_char(cur_byte)) begin
                        emit = 1'b1; emit_kind = TOK_STR_ESC; emit_data = cur_byte;
                        state_d = ST_STRING;
                    end else begin
                        raise_err = 1'b1;
                    end
                end
                ST_NUMBER: begin
                    if (is_num_char(cur_byte)) begin
                        emit = 1'b1; emit_kind = TOK_NUM_CHAR; emit_data = cur_byte;
                    end else begin
                        // Terminator belongs to the next token: park it for replay.
                        emit = 1'b1; emit_kind = TOK_NUM_END;
                        replay_d = cur_byte;
                        pend_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_LITERAL: begin
                    if (cur_byte == lit_char(lit_sel_q, lit_idx_q)) begin
                        if (lit_idx_q == lit_last(lit_sel_q)) begin
                            emit = 1'b1; emit_kind = lit_tok(lit_sel_q);
                            lit_idx_d = 3'd0;
                            state_d   = ST_IDLE;
                        end else begin
                            lit_idx_d = lit_idx_q + 3'd1;
                        end
                    end else begin
                        raise_err = 1'b1;
                    end
                end
                default: begin
                    emit = 1'b0;
                end
            endcase

            // Any lexical fault: one ERROR token, then locked until reset.
            if (raise_err) begin
                emit      = 1'b1;
                emit_kind = TOK_ERROR;
                emit_data = 8'h00;
                err_d     = 1'b1;
                lit_idx_d = 3'd0;
                state_d   = ST_ERROR;
            end
        end

        if (emit) begin
            tok_valid_d = 1'b1;
            tok_kind_d  = emit_kind;
            tok_data_d  = emit_data;
        end
    end

    // Outputs: registered token slot, combinational byte-accept.
    always_comb begin
        in_ready  = rst_n && slot_free && !pend_q && (state_q != ST_ERROR);
        tok_valid = tok_valid_q;
        tok_kind  = tok_kind_q;
        tok_data  = tok_data_q;
        err       = err_q;
    end

endmodule

// File: doc/json_lexer.md
JSON_LEXER -- requirements
Module: json_lexer

Interface
REQ-001 Parameter STRICT_CTRL, default 1, meaning: 1 = raw byte < 0x20 inside a string is an error; 0 = passed through as STR_CHAR.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  input byte valid.
REQ-005 in_ready  output  1  lexer accepts byte this cycle.
REQ-006 in_data  input  8  ASCII byte of JSON text.
REQ-007 tok_valid  output  1  token valid.
REQ-008 tok_ready  input  1  downstream parser accepts token.
REQ-009 tok_kind  output  4  token kind, type json_tok_e.
REQ-010 tok_data  output  8  payload byte (string/number char), else 0x00.
REQ-011 err  output  1  sticky lexical error flag.

Function
REQ-012 Byte transfer occurs when in_valid && in_ready; token transfer when tok_valid && tok_ready.
REQ-013 Output is a single registered slot: in_ready = (!tok_valid || tok_ready) && !pend && state != ERROR.
REQ-014 Latency: accepted byte producing a token drives tok_valid on the next clk edge.
REQ-015 tok_valid, tok_kind, tok_data stay stable while tok_valid && !tok_ready.
REQ-016 States: IDLE, STRING, ESCAPE, NUMBER, LITERAL, ERROR.
REQ-017 IDLE: 0x20/0x09/0x0A/0x0D dropped, no token; { } [ ] : , emit LBRACE/RBRACE/LBRACK/RBRACK/COLON/COMMA.
REQ-018 IDLE: '"' emits STR_START, go STRING; '-' or '0'-'9' emits NUM_CHAR with byte, go NUMBER; 't'/'f'/'n' go LITERAL, no token.
REQ-019 IDLE: any other byte emits ERROR token, go ERROR.
REQ-020 STRING: '"' emits STR_END, go IDLE; '\' emits nothing, go ESCAPE; other byte emits STR_CHAR with byte.
REQ-021 ESCAPE: one of " \ / b f n r t u emits STR_CHAR with the escape letter and a STR_ESC kind; return STRING; other byte -> ERROR.
REQ-022 NUMBER: '0'-'9' . e E + - emit NUM_CHAR; any other byte emits NUM_END, is stored in replay register, pend=1, go IDLE.
REQ-023 While pend=1 the stored byte is processed as an IDLE input at next output-slot availability, then pend=0; in_ready low meanwhile.
REQ-024 LITERAL: 3-bit index counter checks bytes against "true"/"false"/"null"; final match emits LIT_TRUE/LIT_FALSE/LIT_NULL, go IDLE; mismatch -> ERROR.
REQ-025 ERROR: emit one ERROR token, set err=1, in_ready=0 until reset.
REQ-026 Backpressure never drops or duplicates bytes or tokens; dropped whitespace still requires the output slot free.

Reset
REQ-027 rst_n low asynchronously forces: state=IDLE, tok_valid=0, tok_kind=NONE(0), tok_data=0x00, err=0, pend=0, literal counter=0.
REQ-028 Reset mid-string/number/literal discards partial token; first token after release depends only on bytes after release.
REQ-029 in_ready is 0 while rst_n=0.

Structure
REQ-030 json_pkg holds json_tok_e (NONE, LBRACE, RBRACE, LBRACK, RBRACK, COLON, COMMA, STR_START, STR_CHAR, STR_ESC, STR_END, NUM_CHAR, NUM_END, LIT_TRUE, LIT_FALSE, LIT_NULL, ERROR -> 5 bits if >16; encoding fixed at 4 bits by merging STR_ESC into STR_CHAR with tok_data high bit clear is forbidden, so tok_kind width is 5).
REQ-031 json_pkg holds lexer state enum and ASCII constants; json_lexer has no sub-modules; literal matcher is inline.
REQ-032 tok_kind width is 5 bits, overriding REQ-009.

Verification
REQ-033 Input `{"a":1}` with tok_ready=1 -> LBRACE, STR_START, STR_CHAR 0x61, STR_END, COLON, NUM_CHAR 0x31, NUM_END, RBRACE; err=0.
REQ-034 Input `[true, null]` -> LBRACK, LIT_TRUE, COMMA, LIT_NULL, RBRACK; space produces no token.
REQ-035 Input `"\n"` -> STR_START, STR_ESC 0x6E, STR_END.
REQ-036 Input `tru x` -> single ERROR token, err=1, in_ready stays 0 for 20 cycles.
REQ-037 Input `-12]` with tok_ready toggling 1/0 each cycle -> NUM_CHAR 0x2D,0x31,0x32, NUM_END, RBRACK, outputs stable while stalled.
REQ-038 Assert rst_n low mid-`"abc`, release, send `,` -> only COMMA emitted, err=0.
